// File: rtl/ntt_r16_stage_scheduler_pkg.sv
// ntt_sched_pkg: shared constants, state encodings and helpers for the radix-16 NTT scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ntt_sched_pkg;

  localparam int RADIX = 16;
  localparam int LOG_R = 4;

  // FSM encodings kept as plain constants so legacy tools can read the state register
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Per-bank address width, widened to 1 so STAGES=1 still yields legal vectors
  function automatic int ma_wp(input int stages);
    return (stages > 1) ? LOG_R * (stages - 1) : 1;
  endfunction

  // Stage-number width, widened to 1 for the single-stage case
  function automatic int stage_w(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

  // Sum of the 16 base-16 digits of v, mod 16 (the bank number of a point index)
  function automatic logic [3:0] digit_sum16(input logic [63:0] v);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < 16; i++) begin
      acc = acc + v[LOG_R*i +: LOG_R];
    end
    return acc;
  endfunction

endpackage

// File: rtl/ntt_r16_stage_scheduler_if.sv
// Scheduler control/index bus: start/hold in, busy/done status and one butterfly group out.
// Latency: n/a (wiring only).
// Backpressure: hold from the consumer stalls group issue; no other flow control.
// Ports: start, hold (to scheduler); busy, ntt_enable, stage, bn_idx (16x4), ma_idx (16xMA), done (from scheduler).
interface ntt_r16_stage_scheduler_if #(
  parameter int STAGES = 3
);
  import ntt_sched_pkg::*;

  localparam int MA_WP = ma_wp(STAGES);
  localparam int SW    = stage_w(STAGES);

  logic                  start;
  logic                  hold;
  logic                  busy;
  logic                  ntt_enable;
  logic [SW-1:0]         stage;
  logic [16*LOG_R-1:0]   bn_idx;
  logic [16*MA_WP-1:0]   ma_idx;
  logic                  done;

  modport master (
    output start, hold,
    input  busy, ntt_enable, stage, bn_idx, ma_idx, done
  );

  modport slave (
    input  start, hold,
    output busy, ntt_enable, stage, bn_idx, ma_idx, done
  );

endinterface

// File: rtl/ntt_r16_stage_scheduler_idx_map.sv
// ntt_r16_idx_map: maps (stage s, group g) to 16 conflict-free (bank, address) lane pairs.
// Latency: combinational.
// Backpressure: none.
// Ports: s, g in; bn (lane j at [4*j +: 4]), ma (lane j at [MA_WP*j +: MA_WP]) out.
module ntt_r16_idx_map
  import ntt_sched_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic [stage_w(STAGES)-1:0]   s,
  input  logic [ma_wp(STAGES)-1:0]     g,
  output logic [16*LOG_R-1:0]          bn,
  output logic [16*ma_wp(STAGES)-1:0]  ma
);

  localparam int MA_WP = ma_wp(STAGES);
  // One digit wider than g; for STAGES=1 the address slice reads constant zero bits
  localparam int IWX   = LOG_R + MA_WP;

  int             sh;
  logic [IWX-1:0] gx;
  logic [IWX-1:0] low_mask;

  // Stage s inserts the lane digit at digit position STAGES-1-s (DIF ordering)
  assign sh       = LOG_R * (STAGES - 1 - int'(s));
  assign gx       = IWX'(g);
  assign low_mask = (IWX'(1) << sh) - IWX'(1);

  for (genvar j = 0; j < RADIX; j++) begin : g_lane
    logic [IWX-1:0] idx;
    // digits of g above the insert point move up one digit; lower digits stay
    assign idx = ((gx & ~low_mask) << LOG_R) | (IWX'(j) << sh) | (gx & low_mask);
    assign bn[LOG_R*j +: LOG_R] = digit_sum16(64'(idx));
    assign ma[MA_WP*j +: MA_WP] = idx[LOG_R +: MA_WP];
  end

endmodule

// File: rtl/ntt_r16_stage_scheduler.sv
// ntt_r16_stage_scheduler: issues one 16-lane butterfly group per cycle for a radix-16 NTT, draining between stages.
// Latency: first group 2 cycles after start is presented; index outputs registered, 1 cycle after issue.
// Backpressure: hold=1 freezes issue (ntt_enable=0 next cycle); drain ignores hold.
// Ports: clk, rst (async, active-high); bus.slave carries start/hold in and busy/ntt_enable/stage/bn_idx/ma_idx/done out.
module ntt_r16_stage_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int PIPE_LAT = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  ntt_r16_stage_scheduler_if.slave        bus
);

  localparam int G     = RADIX ** (STAGES - 1);
  localparam int MA_WP = ma_wp(STAGES);
  localparam int SW    = stage_w(STAGES);
  localparam int DW    = $clog2(PIPE_LAT + 1);

  logic [1:0]             state;
  logic [SW-1:0]          s;
  logic [MA_WP-1:0]       g;
  logic [DW-1:0]          d;
  logic [16*LOG_R-1:0]    bn_w;
  logic [16*MA_WP-1:0]    ma_w;
  logic                   issue;

  ntt_r16_idx_map #(.STAGES(STAGES)) u_idx_map (
    .s  (s),
    .g  (g),
    .bn (bn_w),
    .ma (ma_w)
  );

  assign issue = (state == ST_ISSUE) && !bus.hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      s              <= '0;
      g              <= '0;
      d              <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.ntt_enable <= 1'b0;
      bus.stage      <= '0;
      bus.bn_idx     <= '0;
      bus.ma_idx     <= '0;
    end else begin
      bus.ntt_enable <= issue;
      bus.done       <= 1'b0;
      // index outputs keep the last group while nothing is issued
      if (issue) begin
        bus.stage  <= s;
        bus.bn_idx <= bn_w;
        bus.ma_idx <= ma_w;
      end

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state    <= ST_ISSUE;
            s        <= '0;
            g        <= '0;
            bus.busy <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (!bus.hold) begin
            if (g == MA_WP'(G - 1)) begin
              g     <= '0;
              d     <= '0;
              state <= ST_DRAIN;
            end else begin
              g <= g + MA_WP'(1);
            end
          end
        end
        ST_DRAIN: begin
          // the next stage's first issue overlaps the last drain cycle, since its
          // outputs only appear one cycle later; the final stage instead ends in DONE
          if (d == DW'(PIPE_LAT - 1)) begin
            d <= '0;
            if (s == SW'(STAGES - 1)) begin
              state <= ST_DONE;
            end else begin
              s     <= s + SW'(1);
              state <= ST_ISSUE;
            end
          end else begin
            d <= d + DW'(1);
          end
        end
        default: begin
          // ST_DONE: the registered pulse lands one cycle after the last drain cycle
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
